ysyx_23060124_wbu_stage: RTL and testbench

Parametrised, registered write-back stage for the ysyx_23060124 multi-cycle/pipelined core. It captures one executed instruction from EXU through a valid/ready handshake and holds it in a one-entry buffer. It retires that instruction to the register file, the CSR file and IFU (PC redirect) only when IFU accepts the next PC. It adds four things to the combinational write-back path: output back-pressure, optional jump-target misalignment trapping, rd addressing, and a retired-instruction counter.

---
 rtl/ysyx_23060124_wbu_pkg.sv | 21 ++
 rtl/ysyx_23060124_wbu_npc.sv | 59 +++++
 rtl/ysyx_23060124_wbu_stage.sv | 120 ++++++++++++
 tb/tb_ysyx_23060124_wbu_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared defaults and types for the ysyx_23060124 write-back stage.
package ysyx_23060124_wbu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 4;
  localparam int CNT_W_DEF  = 64;

  // mcause value for instruction-address-misaligned
  localparam logic [3:0] CAUSE_INST_MISALIGNED = 4'd0;

  typedef struct packed {
    logic wen;
    logic csr_wen;
    logic brch;
    logic jal;
    logic jalr;
    logic mret;
    logic ecall;
  } wbu_flags_t;

endpackage

// File: rtl/ysyx_23060124_wbu_npc.sv
// Next-PC, misalignment and register write-data selection for the
// buffered write-back instruction.
module ysyx_23060124_wbu_npc #(
  parameter int XLEN        = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] res,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            brch,
  input  logic            jal,
  input  logic            jalr,
  input  logic            mret,
  input  logic            ecall,
  output logic [XLEN-1:0] pc_next,
  output logic            mis,
  output logic [XLEN-1:0] rd_wdata
);

  logic [XLEN-1:0] snpc;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic            jump_taken;

  assign snpc     = pc + XLEN'(4);
  assign pc_imm   = pc + imm;
  assign jalr_tgt = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};

  always_comb begin
    jump_taken = 1'b0;
    target     = pc_imm;
    pc_next    = snpc;
    mis        = 1'b0;

    if (jal) begin
      jump_taken = 1'b1;
    end else if (jalr) begin
      jump_taken = 1'b1;
      target     = jalr_tgt;
    end else if (brch && res[0]) begin
      jump_taken = 1'b1;
    end

    if (jump_taken)  pc_next = target;
    else if (ecall)  pc_next = mtvec;
    else if (mret)   pc_next = mepc;

    // A misaligned taken target vectors to the trap handler instead.
    mis = ALIGN_CHECK && jump_taken && target[1];
    if (mis) pc_next = mtvec;
  end

  assign rd_wdata = (jal || jalr) ? snpc : res;

endmodule

// File: rtl/ysyx_23060124_wbu_stage.sv
// Registered write-back stage: one-entry buffer between EXU and IFU with
// retire strobes for the register/CSR files and a retired-instruction counter.
module ysyx_23060124_wbu_stage
  import ysyx_23060124_wbu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_res,
  input  logic [XLEN-1:0]   i_mepc,
  input  logic [XLEN-1:0]   i_mtvec,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_wen,
  input  logic              i_csr_wen,
  input  logic              i_brch,
  input  logic              i_jal,
  input  logic              i_jalr,
  input  logic              i_mret,
  input  logic              i_ecall,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic [XLEN-1:0]   o_pc_next,
  output logic [REG_AW-1:0] o_rd,
  output logic [XLEN-1:0]   o_rd_wdata,
  output logic              o_wbu_wen,
  output logic [XLEN-1:0]   o_csr_rd,
  output logic              o_wbu_csr_wen,
  output logic              o_trap,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  logic              full_reg;
  logic [XLEN-1:0]   pc_reg, rs1_reg, imm_reg, res_reg, mepc_reg, mtvec_reg;
  logic [REG_AW-1:0] rd_reg;
  wbu_flags_t        flags_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic            acc;
  logic            ret;
  logic            mis;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] rd_wdata;

  assign ret         = full_reg && i_post_ready;
  assign o_pre_ready = !full_reg || ret;
  assign acc         = i_pre_valid && o_pre_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      full_reg  <= 1'b0;
      pc_reg    <= '0;
      rs1_reg   <= '0;
      imm_reg   <= '0;
      res_reg   <= '0;
      mepc_reg  <= '0;
      mtvec_reg <= '0;
      rd_reg    <= '0;
      flags_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      if (acc)      full_reg <= 1'b1;
      else if (ret) full_reg <= 1'b0;

      if (acc) begin
        pc_reg    <= i_pc;
        rs1_reg   <= i_rs1;
        imm_reg   <= i_imm;
        res_reg   <= i_res;
        mepc_reg  <= i_mepc;
        mtvec_reg <= i_mtvec;
        rd_reg    <= i_rd;
        flags_reg <= '{wen: i_wen, csr_wen: i_csr_wen, brch: i_brch,
                       jal: i_jal, jalr: i_jalr, mret: i_mret, ecall: i_ecall};
      end

      if (ret) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  ysyx_23060124_wbu_npc #(
    .XLEN        (XLEN),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_npc (
    .pc       (pc_reg),
    .rs1      (rs1_reg),
    .imm      (imm_reg),
    .res      (res_reg),
    .mepc     (mepc_reg),
    .mtvec    (mtvec_reg),
    .brch     (flags_reg.brch),
    .jal      (flags_reg.jal),
    .jalr     (flags_reg.jalr),
    .mret     (flags_reg.mret),
    .ecall    (flags_reg.ecall),
    .pc_next  (npc),
    .mis      (mis),
    .rd_wdata (rd_wdata)
  );

  assign o_post_valid  = full_reg;
  // Empty buffer presents a zero next-PC rather than the stale pc+4.
  assign o_pc_next     = full_reg ? npc : '0;
  assign o_rd          = rd_reg;
  assign o_rd_wdata    = rd_wdata;
  assign o_csr_rd      = res_reg;
  assign o_trap        = full_reg && mis;
  assign o_wbu_wen     = ret && flags_reg.wen && !mis;
  assign o_wbu_csr_wen = ret && flags_reg.csr_wen && !mis;
  assign o_retire_cnt  = cnt_reg;

endmodule

// File: tb/tb_ysyx_23060124_wbu_stage.sv
// Directed bench for the write-back stage; a second instance with the
// alignment check disabled shares the same stimulus.
module tb_ysyx_23060124_wbu_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_pre_valid, i_post_ready;
  logic [31:0] i_pc, i_rs1, i_imm, i_res, i_mepc, i_mtvec;
  logic [3:0]  i_rd;
  logic        i_wen, i_csr_wen, i_brch, i_jal, i_jalr, i_mret, i_ecall;

  logic        o_pre_ready, o_post_valid, o_wbu_wen, o_wbu_csr_wen, o_trap;
  logic [31:0] o_pc_next, o_rd_wdata, o_csr_rd;
  logic [3:0]  o_rd;
  logic [63:0] o_retire_cnt;

  logic        n_pre_ready, n_post_valid, n_wbu_wen, n_wbu_csr_wen, n_trap;
  logic [31:0] n_pc_next, n_rd_wdata, n_csr_rd;
  logic [3:0]  n_rd;
  logic [63:0] n_retire_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ysyx_23060124_wbu_stage #(.ALIGN_CHECK(1'b1)) dut (
    .clock(clock), .reset(reset), .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .i_pc(i_pc), .i_rs1(i_rs1), .i_imm(i_imm), .i_res(i_res), .i_mepc(i_mepc),
    .i_mtvec(i_mtvec), .i_rd(i_rd), .i_wen(i_wen), .i_csr_wen(i_csr_wen),
    .i_brch(i_brch), .i_jal(i_jal), .i_jalr(i_jalr), .i_mret(i_mret), .i_ecall(i_ecall),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready), .o_pc_next(o_pc_next),
    .o_rd(o_rd), .o_rd_wdata(o_rd_wdata), .o_wbu_wen(o_wbu_wen), .o_csr_rd(o_csr_rd),
    .o_wbu_csr_wen(o_wbu_csr_wen), .o_trap(o_trap), .o_retire_cnt(o_retire_cnt)
  );

  ysyx_23060124_wbu_stage #(.ALIGN_CHECK(1'b0)) dut_nochk (
    .clock(clock), .reset(reset), .i_pre_valid(i_pre_valid), .o_pre_ready(n_pre_ready),
    .i_pc(i_pc), .i_rs1(i_rs1), .i_imm(i_imm), .i_res(i_res), .i_mepc(i_mepc),
    .i_mtvec(i_mtvec), .i_rd(i_rd), .i_wen(i_wen), .i_csr_wen(i_csr_wen),
    .i_brch(i_brch), .i_jal(i_jal), .i_jalr(i_jalr), .i_mret(i_mret), .i_ecall(i_ecall),
    .o_post_valid(n_post_valid), .i_post_ready(i_post_ready), .o_pc_next(n_pc_next),
    .o_rd(n_rd), .o_rd_wdata(n_rd_wdata), .o_wbu_wen(n_wbu_wen), .o_csr_rd(n_csr_rd),
    .o_wbu_csr_wen(n_wbu_csr_wen), .o_trap(n_trap), .o_retire_cnt(n_retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    i_pc = '0; i_rs1 = '0; i_imm = '0; i_res = '0; i_mepc = '0; i_mtvec = '0;
    i_rd = '0; i_wen = 0; i_csr_wen = 0; i_brch = 0; i_jal = 0; i_jalr = 0;
    i_mret = 0; i_ecall = 0;
  endtask

  // Offer the current inputs for one cycle; returns #1 after the accepting edge.
  task automatic issue();
    i_pre_valid = 1'b1;
    tick();
    i_pre_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b0;
    clear_in();
    tick(); tick();
    $display("txn reset");
    check("rst_post_valid", 64'(o_post_valid), 64'd0);
    check("rst_pre_ready", 64'(o_pre_ready), 64'd1);
    check("rst_cnt", o_retire_cnt, 64'd0);
    check("rst_pc_next", 64'(o_pc_next), 64'd0);
    check("rst_rd_wdata", 64'(o_rd_wdata), 64'd0);
    check("rst_strobes", 64'({o_wbu_wen, o_wbu_csr_wen, o_trap}), 64'd0);
    reset = 1'b0;
    i_post_ready = 1'b1;

    // Plain ALU op
    i_pc = 32'h8000_0000; i_wen = 1; i_rd = 4'd5; i_res = 32'h1234;
    issue();
    $display("txn alu pc=%h", i_pc);
    check("alu_valid", 64'(o_post_valid), 64'd1);
    check("alu_wen", 64'(o_wbu_wen), 64'd1);
    check("alu_rd", 64'(o_rd), 64'd5);
    check("alu_wdata", 64'(o_rd_wdata), 64'h1234);
    check("alu_npc", 64'(o_pc_next), 64'h8000_0004);
    check("alu_cnt_before", o_retire_cnt, 64'd0);
    tick();
    check("alu_cnt", o_retire_cnt, 64'd1);
    check("alu_empty", 64'(o_post_valid), 64'd0);
    check("alu_wen_gone", 64'(o_wbu_wen), 64'd0);

    // Aligned jalr clears bit 0
    clear_in();
    i_pc = 32'h8000_0010; i_rs1 = 32'h8000_0101; i_jalr = 1; i_wen = 1; i_rd = 4'd1;
    i_mtvec = 32'h8000_2000;
    issue();
    $display("txn jalr aligned");
    check("jalr_npc", 64'(o_pc_next), 64'h8000_0100);
    check("jalr_wdata", 64'(o_rd_wdata), 64'h8000_0014);
    check("jalr_trap", 64'(o_trap), 64'd0);
    check("jalr_wen", 64'(o_wbu_wen), 64'd1);
    tick();
    check("jalr_cnt", o_retire_cnt, 64'd2);

    // Misaligned jalr: trap in checked instance, plain jump in the other
    i_rs1 = 32'h8000_0102;
    issue();
    $display("txn jalr misaligned");
    check("mis_npc", 64'(o_pc_next), 64'h8000_2000);
    check("mis_trap", 64'(o_trap), 64'd1);
    check("mis_wen", 64'(o_wbu_wen), 64'd0);
    check("nochk_npc", 64'(n_pc_next), 64'h8000_0102);
    check("nochk_trap", 64'(n_trap), 64'd0);
    check("nochk_wen", 64'(n_wbu_wen), 64'd1);
    tick();
    check("mis_cnt", o_retire_cnt, 64'd3);
    check("nochk_cnt", n_retire_cnt, 64'd3);

    // Back-pressure: B buffered, C offered while stalled
    clear_in();
    i_post_ready = 1'b0;
    i_pc = 32'h100; i_res = 32'hB; i_wen = 1; i_rd = 4'd2; i_csr_wen = 1;
    i_pre_valid = 1'b1;
    tick();
    i_pc = 32'h200; i_res = 32'hC; i_rd = 4'd3; i_csr_wen = 0;
    for (int c = 0; c < 3; c++) begin
      $display("txn stall cycle %0d", c);
      check("stall_pre_ready", 64'(o_pre_ready), 64'd0);
      check("stall_wdata", 64'(o_rd_wdata), 64'hB);
      check("stall_npc", 64'(o_pc_next), 64'h104);
      check("stall_strobes", 64'({o_wbu_wen, o_wbu_csr_wen}), 64'd0);
      tick();
    end
    i_post_ready = 1'b1;
    #1;
    $display("txn stall release B");
    check("rel_b_wen", 64'({o_wbu_wen, o_wbu_csr_wen}), 64'h3);
    check("rel_b_wdata", 64'(o_rd_wdata), 64'hB);
    check("rel_b_csr", 64'(o_csr_rd), 64'hB);
    check("rel_pre_ready", 64'(o_pre_ready), 64'd1);
    tick();
    i_pre_valid = 1'b0;
    $display("txn stall release C");
    check("rel_c_wen", 64'({o_wbu_wen, o_wbu_csr_wen}), 64'h2);
    check("rel_c_rd", 64'(o_rd), 64'd3);
    check("rel_c_wdata", 64'(o_rd_wdata), 64'hC);
    tick();
    check("rel_cnt", o_retire_cnt, 64'd5);

    // Streaming from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    clear_in();
    i_wen = 1; i_rd = 4'd7; i_pc = 32'h8000_0000;
    i_pre_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      i_res = k;
      tick();
      if (!o_pre_ready) check("stream_pre_ready", 64'(o_pre_ready), 64'd1);
    end
    i_pre_valid = 1'b0;
    $display("txn stream last");
    check("stream_last_wdata", 64'(o_rd_wdata), 64'd99);
    tick();
    check("stream_cnt", o_retire_cnt, 64'd100);

    // Reset while an instruction is buffered
    i_pre_valid = 1'b1; tick(); tick();
    check("mid_cnt_pre", o_retire_cnt, 64'd101);
    reset = 1'b1;
    tick();
    reset = 1'b0; i_pre_valid = 1'b0;
    $display("txn mid-stream reset");
    check("mid_valid", 64'(o_post_valid), 64'd0);
    check("mid_wen", 64'(o_wbu_wen), 64'd0);
    check("mid_cnt", o_retire_cnt, 64'd0);
    tick();
    check("mid_cnt_after", o_retire_cnt, 64'd0);

    // ecall / mret / ecall+jal priority
    clear_in();
    i_pc = 32'h8000_0300; i_ecall = 1; i_mtvec = 32'h8000_1000;
    issue();
    $display("txn ecall");
    check("ecall_npc", 64'(o_pc_next), 64'h8000_1000);
    tick();
    clear_in();
    i_pc = 32'h8000_0300; i_mret = 1; i_mepc = 32'h8000_0040;
    issue();
    $display("txn mret");
    check("mret_npc", 64'(o_pc_next), 64'h8000_0040);
    tick();
    clear_in();
    i_pc = 32'h8000_0300; i_imm = 32'h20; i_ecall = 1; i_jal = 1; i_mtvec = 32'h8000_1000;
    issue();
    $display("txn ecall+jal");
    check("ecjal_npc", 64'(o_pc_next), 64'h8000_0320);
    check("ecjal_wdata", 64'(o_rd_wdata), 64'h8000_0304);
    check("ecjal_trap", 64'(o_trap), 64'd0);
    tick();

    // Branches and PC wrap
    clear_in();
    i_pc = 32'h8000_0400; i_imm = 32'hFFFF_FFF8; i_brch = 1; i_res = 32'd1;
    issue();
    $display("txn branch taken");
    check("br_taken_npc", 64'(o_pc_next), 64'h8000_03F8);
    tick();
    i_res = 32'd0;
    issue();
    $display("txn branch not taken");
    check("br_nt_npc", 64'(o_pc_next), 64'h8000_0404);
    tick();
    clear_in();
    i_pc = 32'hFFFF_FFFC;
    issue();
    $display("txn pc wrap");
    check("wrap_npc", 64'(o_pc_next), 64'd0);
    tick();
    check("final_cnt", o_retire_cnt, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
